palette_colorizer: RTL and testbench

Parametrised pixel colorizer between the display timing generator, the world-map/icon pixel sources and the VGA output pins. It maps a world-map pixel code and an icon pixel code to one RGB value using two run-time-writable palettes. It adds an optional frame-counted icon blink and a fixed 2-cycle registered pipeline. It supersedes the fixed-colour colorizer; with default parameters and reset palettes its colours match that block's white/black/red/magenta world and green icon.

---
 rtl/palette_colorizer.sv | 107 ++++++++++
 tb/tb_palette_colorizer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/palette_colorizer.sv
// rtl/palette_colorizer.sv - maps world/icon pixel codes to RGB through two writable palettes,
// with frame-counted icon blink and a 2-stage registered pipeline.
module palette_colorizer #(
  parameter int CW           = 4,
  parameter int PW           = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            video_on,
  input  logic            frame_tick,
  input  logic [PW-1:0]   world_pixel,
  input  logic [PW-1:0]   icon,
  input  logic            blink_en,
  input  logic            pal_we,
  input  logic            pal_sel,
  input  logic [PW-1:0]   pal_addr,
  input  logic [3*CW-1:0] pal_data,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue
);

  localparam int RW    = 3 * CW;
  localparam int DEPTH = 1 << PW;
  localparam logic [CW-1:0] FULL = '1;
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  function automatic logic [RW-1:0] world_init(input int idx);
    case (idx)
      1:       world_init = {ZERO, ZERO, ZERO};
      2:       world_init = {FULL, ZERO, ZERO};
      3:       world_init = {FULL, ZERO, FULL};
      default: world_init = {FULL, FULL, FULL};
    endcase
  endfunction

  function automatic logic [RW-1:0] icon_init(input int idx);
    icon_init = (idx == 0) ? {ZERO, ZERO, ZERO} : {ZERO, FULL, ZERO};
  endfunction

  logic [RW-1:0] world_pal [DEPTH];
  logic [RW-1:0] icon_pal  [DEPTH];

  logic [7:0]    blink_cnt;
  logic          blink_phase;

  logic          s1_video;
  logic [PW-1:0] s1_world;
  logic [PW-1:0] s1_icon;
  logic          s1_icon_vis;
  logic [RW-1:0] rgb;

  // Reset takes priority, so a write presented during reset is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        world_pal[i] <= world_init(i);
        icon_pal[i]  <= icon_init(i);
      end
    end else if (pal_we) begin
      if (pal_sel) icon_pal[pal_addr]  <= pal_data;
      else         world_pal[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !blink_en) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_video    <= 1'b0;
      s1_world    <= '0;
      s1_icon     <= '0;
      s1_icon_vis <= 1'b0;
    end else begin
      s1_video    <= video_on;
      s1_world    <= world_pixel;
      s1_icon     <= icon;
      s1_icon_vis <= (icon != '0) && !(blink_en && blink_phase);
    end
  end

  // Palette lookup happens here, so a write at edge e is seen by the pixel sampled at e.
  always_ff @(posedge clock) begin
    if (reset || !s1_video) rgb <= '0;
    else if (s1_icon_vis)   rgb <= icon_pal[s1_icon];
    else                    rgb <= world_pal[s1_world];
  end

  assign red   = rgb[RW-1 -: CW];
  assign green = rgb[2*CW-1 -: CW];
  assign blue  = rgb[CW-1:0];

endmodule

// File: tb/tb_palette_colorizer.sv
// tb/tb_palette_colorizer.sv - scoreboard bench for palette_colorizer (CW=5, PW=3, BLINK_FRAMES=2)
module tb_palette_colorizer;

  localparam int CW = 5;
  localparam int PW = 3;
  localparam int BF = 2;

  logic          clock;
  logic          reset;
  logic          video_on;
  logic          frame_tick;
  logic [PW-1:0] world_pixel;
  logic [PW-1:0] icon;
  logic          blink_en;
  logic          pal_we;
  logic          pal_sel;
  logic [PW-1:0] pal_addr;
  logic [14:0]   pal_data;
  logic [CW-1:0] red, green, blue;

  palette_colorizer #(.CW(CW), .PW(PW), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
    .world_pixel(world_pixel), .icon(icon), .blink_en(blink_en), .pal_we(pal_we),
    .pal_sel(pal_sel), .pal_addr(pal_addr), .pal_data(pal_data),
    .red(red), .green(green), .blue(blue)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [14:0] m_world [8];
  logic [14:0] m_icon  [8];
  int          m_cnt;
  logic        m_phase;
  logic [14:0] m_pend;
  logic [14:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;

  task automatic model_reset();
    m_world[0] = 15'h7FFF;
    m_world[1] = 15'h0000;
    m_world[2] = 15'h7C00;
    m_world[3] = 15'h7C1F;
    for (int i = 4; i < 8; i++) m_world[i] = 15'h7FFF;
    m_icon[0] = 15'h0000;
    for (int i = 1; i < 8; i++) m_icon[i] = 15'h03E0;
  endtask

  task automatic step(input logic rst, input logic vid, input logic tick, input logic ben,
                      input logic [2:0] wp, input logic [2:0] ic, input logic we,
                      input logic sel, input logic [2:0] addr, input logic [14:0] data);
    logic [14:0] pix;
    @(negedge clock);
    reset = rst; video_on = vid; frame_tick = tick; blink_en = ben;
    world_pixel = wp; icon = ic; pal_we = we; pal_sel = sel; pal_addr = addr; pal_data = data;
    exp_q.push_back(rst ? 15'h0000 : m_pend);
    if (rst) model_reset();
    else if (we) begin
      if (sel) m_icon[addr] = data;
      else     m_world[addr] = data;
    end
    if (rst || !vid) pix = 15'h0000;
    else if (ic != 3'd0 && !(ben && m_phase)) pix = m_icon[ic];
    else pix = m_world[wp];
    if (rst || !ben) begin
      m_cnt = 0;
      m_phase = 1'b0;
    end else if (tick) begin
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else m_cnt++;
    end
    m_pend = pix;
  endtask

  task automatic pixel(input logic vid, input logic [2:0] wp, input logic [2:0] ic);
    step(1'b0, vid, 1'b0, 1'b0, wp, ic, 1'b0, 1'b0, 3'd0, 15'h0);
  endtask

  initial begin
    logic ben;
    reset = 1'b1; video_on = 1'b0; frame_tick = 1'b0; blink_en = 1'b0;
    world_pixel = '0; icon = '0; pal_we = 1'b0; pal_sel = 1'b0; pal_addr = '0; pal_data = '0;
    model_reset();
    m_cnt = 0; m_phase = 1'b0; m_pend = 15'h0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 15'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 15'h0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 3'(i), 3'd0);
    for (int i = 0; i < 3; i++) pixel(1'b0, 3'd2, 3'd0);

    for (int i = 0; i < 3; i++) pixel(1'b1, 3'd1, 3'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b1, 3'd2, 15'h001F);
    for (int i = 0; i < 3; i++) pixel(1'b1, 3'd1, 3'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, 1'b1, 3'd0, 15'h7FFF);
    pixel(1'b1, 3'd3, 3'd0);

    for (int i = 0; i < 60; i++)
      step(1'b0, 1'b1, (i % 10) == 9, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 15'h0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 3'd1, 3'd1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 15'h0123);
    pixel(1'b1, 3'd0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 15'h0456);
    for (int i = 0; i < 3; i++) pixel(1'b1, 3'd0, 3'd0);

    ben = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 199) == 0) ben = !ben;
      step($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           ben, 3'($urandom()), ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom()),
           $urandom_range(0, 19) == 0, 1'($urandom()), 3'($urandom()), 15'($urandom()));
    end
    pixel(1'b0, 3'd0, 3'd0);
    @(negedge clock);
    done = 1'b1;
  end

  initial begin
    logic [14:0] want;
    logic [14:0] got;
    int edge_n;
    edge_n = 0;
    forever begin
      @(posedge clock);
      #1;
      edge_n++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {red, green, blue};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL rgb edge=%0d got=%h want=%h", edge_n, got, want);
        end
      end else if (done) begin
        if (total < 10000) begin
          $display("FAIL count: only %0d pixels scored", total);
        end
        if (bad != 0) begin
          $display("FAIL summary: %0d of %0d pixels mismatched", bad, total);
        end else begin
          $display("PASS: %0d pixels matched", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
